// File: rtl/ttt_move_sequencer.sv
// ttt_move_sequencer: turn controller that validates, strobes and hands over moves for the tic_tac_toe core
module ttt_move_sequencer #(
   parameter int unsigned HOLD_CYCLES    = 5,
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        player_req,
   input  logic [3:0]  player_sel,
   input  logic        computer_req,
   input  logic [3:0]  computer_sel,
   input  logic [17:0] board,
   input  logic [1:0]  who,
   output logic        play,
   output logic        pc,
   output logic [3:0]  player_position,
   output logic [3:0]  computer_position,
   output logic        accept,
   output logic        reject,
   output logic        turn,
   output logic [3:0]  move_count,
   output logic        game_over,
   output logic        timeout
);
   localparam logic [2:0] P_WAIT   = 3'd0;
   localparam logic [2:0] P_ISSUE  = 3'd1;
   localparam logic [2:0] P_SETTLE = 3'd2;
   localparam logic [2:0] C_WAIT   = 3'd3;
   localparam logic [2:0] C_ISSUE  = 3'd4;
   localparam logic [2:0] C_SETTLE = 3'd5;
   localparam logic [2:0] DONE     = 3'd6;
   localparam logic [3:0] HOLD        = 4'(HOLD_CYCLES);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [15:0] TLIM       = 16'(TIMEOUT_CYCLES);

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic        play_q, play_d, pc_q, pc_d;
   logic [3:0]  ppos_q, ppos_d, cpos_q, cpos_d;
   logic        accept_q, accept_d, reject_q, reject_d;
   logic        turn_q, turn_d, over_q, over_d, timeout_q, timeout_d;
   logic [3:0]  mc_q, mc_d, mc_next;
   logic [17:0] p_shift, c_shift;
   logic        p_legal, c_legal;

   // A requested cell is legal only if it exists and is still empty; move count saturates at 9
   always_comb begin
      p_shift = board >> {player_sel, 1'b0};
      c_shift = board >> {computer_sel, 1'b0};
      p_legal = (player_sel <= 4'd8) && (p_shift[1:0] == 2'b00);
      c_legal = (computer_sel <= 4'd8) && (c_shift[1:0] == 2'b00);
      mc_next = (mc_q == 4'd9) ? 4'd9 : mc_q + 4'd1;
   end

   // Turn FSM: wait for a legal request, hold the strobe, let the board settle, then hand over or finish
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tcnt_d    = tcnt_q;
      play_d    = 1'b0;
      pc_d      = 1'b0;
      ppos_d    = ppos_q;
      cpos_d    = cpos_q;
      accept_d  = 1'b0;
      reject_d  = 1'b0;
      turn_d    = turn_q;
      mc_d      = mc_q;
      over_d    = over_q;
      timeout_d = timeout_q;
      case (state_q)
         P_WAIT: if (player_req) begin
            accept_d = p_legal;
            reject_d = !p_legal;
            if (p_legal) begin
               ppos_d  = player_sel;
               cnt_d   = 4'd0;
               state_d = P_ISSUE;
            end
         end
         P_ISSUE: if (cnt_q == HOLD) begin
            cnt_d   = 4'd0;
            state_d = P_SETTLE;
         end else begin
            cnt_d  = cnt_q + 4'd1;
            play_d = 1'b1;
         end
         P_SETTLE: if (cnt_q == SETTLE_LAST) begin
            cnt_d = 4'd0;
            mc_d  = mc_next;
            if (who != 2'b00 || mc_next == 4'd9) begin
               over_d  = 1'b1;
               state_d = DONE;
            end else begin
               turn_d  = 1'b1;
               tcnt_d  = 16'd0;
               state_d = C_WAIT;
            end
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
         C_WAIT: if (computer_req) begin
            tcnt_d   = 16'd0;
            accept_d = c_legal;
            reject_d = !c_legal;
            if (c_legal) begin
               cpos_d    = computer_sel;
               cnt_d     = 4'd0;
               timeout_d = 1'b0;
               state_d   = C_ISSUE;
            end
         end else begin
            tcnt_d = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
            if (tcnt_d == TLIM) timeout_d = 1'b1;
         end
         C_ISSUE: if (cnt_q == HOLD) begin
            cnt_d   = 4'd0;
            state_d = C_SETTLE;
         end else begin
            cnt_d = cnt_q + 4'd1;
            pc_d  = 1'b1;
         end
         C_SETTLE: if (cnt_q == SETTLE_LAST) begin
            cnt_d = 4'd0;
            mc_d  = mc_next;
            if (who != 2'b00 || mc_next == 4'd9) begin
               over_d  = 1'b1;
               state_d = DONE;
            end else begin
               turn_d  = 1'b0;
               state_d = P_WAIT;
            end
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
         DONE: over_d = 1'b1;
         default: state_d = P_WAIT;
      endcase
   end

   // State registers with synchronous active-low reset that also kills any strobe in flight
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= P_WAIT;
         cnt_q     <= 4'd0;
         tcnt_q    <= 16'd0;
         play_q    <= 1'b0;
         pc_q      <= 1'b0;
         ppos_q    <= 4'd0;
         cpos_q    <= 4'd0;
         accept_q  <= 1'b0;
         reject_q  <= 1'b0;
         turn_q    <= 1'b0;
         mc_q      <= 4'd0;
         over_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tcnt_q    <= tcnt_d;
         play_q    <= play_d;
         pc_q      <= pc_d;
         ppos_q    <= ppos_d;
         cpos_q    <= cpos_d;
         accept_q  <= accept_d;
         reject_q  <= reject_d;
         turn_q    <= turn_d;
         mc_q      <= mc_d;
         over_q    <= over_d;
         timeout_q <= timeout_d;
      end
   end

   assign play              = play_q;
   assign pc                = pc_q;
   assign player_position   = ppos_q;
   assign computer_position = cpos_q;
   assign accept            = accept_q;
   assign reject            = reject_q;
   assign turn              = turn_q;
   assign move_count        = mc_q;
   assign game_over         = over_q;
   assign timeout           = timeout_q;
endmodule

// File: tb/tb_ttt_move_sequencer.sv
// tb_ttt_move_sequencer: randomized games against a board/line model acting as the tic_tac_toe core
module tb_ttt_move_sequencer;
   localparam int H  = 5;
   localparam int S  = 2;
   localparam int TO = 200;
   localparam int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        player_req = 1'b0, computer_req = 1'b0;
   logic [3:0]  player_sel = 4'd0, computer_sel = 4'd0;
   logic [17:0] board;
   logic [1:0]  who, judged;
   logic        play, pc, accept, reject, turn, game_over, timeout;
   logic [3:0]  player_position, computer_position, move_count;
   logic [1:0]  cells [9];
   logic        who_ovr_en = 1'b0;
   logic [1:0]  who_ovr = 2'b00;
   int          n_cmp = 0, n_bad = 0, mc = 0;
   bit          over_m = 1'b0;

   ttt_move_sequencer #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .player_req(player_req), .player_sel(player_sel),
      .computer_req(computer_req), .computer_sel(computer_sel),
      .board(board), .who(who),
      .play(play), .pc(pc),
      .player_position(player_position), .computer_position(computer_position),
      .accept(accept), .reject(reject), .turn(turn),
      .move_count(move_count), .game_over(game_over), .timeout(timeout)
   );

   initial forever #5 clock = ~clock;

   // Core model: board bits from the cell array, result from the eight lines or a full board
   always_comb begin
      board  = '0;
      judged = 2'b11;
      for (int k = 0; k < 9; k++) begin
         board[2*k +: 2] = cells[k];
         if (cells[k] == 2'b00) judged = 2'b00;
      end
      for (int l = 0; l < 8; l++)
         if (cells[LN[l][0]] != 2'b00 && cells[LN[l][0]] == cells[LN[l][1]] && cells[LN[l][0]] == cells[LN[l][2]])
            judged = cells[LN[l][0]];
      who = who_ovr_en ? who_ovr : judged;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      player_req   = 1'b0;
      computer_req = 1'b0;
   endtask

   task automatic noise();
      player_req   = 1'($urandom_range(0, 1));
      computer_req = 1'($urandom_range(0, 1));
      player_sel   = 4'($urandom_range(0, 15));
      computer_sel = 4'($urandom_range(0, 15));
   endtask

   task automatic do_reset();
      quiet();
      reset = 1'b0;
      tick();
      check("rst_strobes", {play, pc, accept, reject}, 4'b0000);
      check("rst_status", {turn, game_over, timeout}, 3'b000);
      check("rst_mc", move_count, 0);
      check("rst_pos", {player_position, computer_position}, 8'h00);
      tick();
      reset = 1'b1;
      for (int k = 0; k < 9; k++) cells[k] = 2'b00;
      mc = 0;
      over_m = 1'b0;
      who_ovr_en = 1'b0;
   endtask

   // One request from the given side; illegal requests are held extra cycles and must reject every cycle
   task automatic move(input bit side, input logic [3:0] sel, input int extra, input logic [2:0] fw);
      bit legal, done;
      int idx;
      logic [1:0] w;
      idx = int'(sel);
      legal = (sel <= 4'd8);
      if (legal) legal = (cells[idx] == 2'b00);
      noise();
      if (side) begin computer_req = 1'b1; computer_sel = sel; end
      else begin player_req = 1'b1; player_sel = sel; end
      if (!legal) begin
         for (int i = 0; i <= extra; i++) begin
            tick();
            check("rej_pulse", {accept, reject}, 2'b01);
            check("rej_nostrobe", {play, pc}, 2'b00);
         end
         quiet();
         tick();
         check("rej_end", {accept, reject}, 2'b00);
         return;
      end
      tick();
      check("acc_pulse", {accept, reject}, 2'b10);
      check("acc_nostrobe", {play, pc}, 2'b00);
      if (side) check("to_clear", timeout, 0);
      for (int k = 1; k <= H; k++) begin
         noise();
         tick();
         check("strobe", {play, pc}, side ? 2'b01 : 2'b10);
         check("pos", side ? computer_position : player_position, sel);
         check("hold_nopulse", {accept, reject}, 2'b00);
         if (k == 1) cells[idx] = side ? 2'b10 : 2'b01;
      end
      noise();
      tick();
      check("strobe_drop", {play, pc}, 2'b00);
      if (fw[2]) begin who_ovr_en = 1'b1; who_ovr = fw[1:0]; end
      for (int k = 1; k < S; k++) begin
         noise();
         tick();
         check("settle_turn", turn, side);
         check("settle_mc", move_count, mc);
      end
      quiet();
      w = who;
      tick();
      mc++;
      done = (w != 2'b00) || (mc == 9);
      check("mc", move_count, mc);
      check("over", game_over, done);
      if (!done) check("handover", turn, !side);
      over_m = done;
   endtask

   task automatic post_done(input int n);
      for (int i = 0; i < n; i++) begin
         noise();
         tick();
         check("done_quiet", {play, pc, accept, reject}, 4'b0000);
         check("done_sticky", game_over, 1);
         check("done_mc", move_count, mc);
      end
      quiet();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int empt[$];
      logic [3:0] sel;
      for (int k = 0; k < 9; k++) cells[k] = 2'b00;
      tick();
      do_reset();

      move(0, 4'd4, 0, 3'b000);
      move(1, 4'd4, 2, 3'b000);
      move(1, 4'd8, 0, 3'b000);
      move(0, 4'd9, 1, 3'b000);
      move(0, 4'd15, 0, 3'b000);
      computer_req = 1'b1;
      computer_sel = 4'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("offturn_c", {accept, reject, pc}, 3'b000);
      end
      quiet();
      move(0, 4'd0, 0, 3'b000);
      move(1, 4'd1, 0, 3'b000);
      move(0, 4'd2, 0, 3'b101);
      check("who_over", over_m, 1);
      post_done(50);

      do_reset();
      move(0, 4'd4, 0, 3'b000);
      for (int i = 1; i < TO; i++) tick();
      check("to_before", timeout, 0);
      tick();
      check("to_set", timeout, 1);
      check("to_turn", turn, 1);
      move(1, 4'd0, 0, 3'b000);

      do_reset();
      player_req = 1'b1;
      player_sel = 4'd2;
      tick();
      check("mid_acc", accept, 1);
      quiet();
      for (int i = 0; i < 3; i++) tick();
      check("mid_play", play, 1);
      reset = 1'b0;
      tick();
      check("mid_rst_strobe", {play, pc}, 2'b00);
      check("mid_rst_mc", move_count, 0);
      check("mid_rst_turn", turn, 0);
      reset = 1'b1;
      for (int k = 0; k < 9; k++) cells[k] = 2'b00;
      mc = 0;
      who_ovr_en = 1'b1;
      who_ovr = 2'b00;
      for (int k = 0; k < 9; k++) move(k[0], 4'(k), 0, 3'b000);
      check("nine_over", over_m, 1);
      check("nine_mc", move_count, 9);
      post_done(10);

      for (int g = 0; g < 15; g++) begin
         do_reset();
         while (!over_m) begin
            empt = {};
            for (int k = 0; k < 9; k++) if (cells[k] == 2'b00) empt.push_back(k);
            if ($urandom_range(0, 3) == 0) sel = 4'($urandom_range(0, 15));
            else sel = 4'(empt[$urandom_range(0, empt.size() - 1)]);
            move(mc[0], sel, int'($urandom_range(0, 2)), 3'b000);
         end
         post_done(5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
